bcd_stopwatch_ctrl: RTL and testbench

//  Sequencing controller for a cascade of BCD decade counters. It turns start/stop/clear/lap

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_digit.sv | 33 +++
 rtl/bcd_stopwatch_ctrl.sv | 131 +++++++++++++
 tb/tb_bcd_stopwatch_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and constants for the BCD stopwatch controller.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10
  } sw_state_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit
// Description : One BCD decade counter; increments on en_i, rolls 9 -> 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [3:0] q_o,
  output logic       at_max_o
);

  bcd_digit_t r_q;

  // Decade register: clear has priority over the enable, 9 rolls to 0.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      r_q <= '0;
    end else if (en_i) begin
      r_q <= (r_q == BCD_MAX) ? 4'd0 : r_q + 4'd1;
    end
  end

  assign q_o      = r_q;
  assign at_max_o = (r_q == BCD_MAX);

endmodule
`default_nettype wire

// File: rtl/bcd_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bcd_stopwatch_ctrl
// Description : Start/stop/clear/lap sequencer with tick prescaler driving a
//               synchronous carry chain of BCD decade counters.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_stopwatch_ctrl
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    clear_i,
  input  logic                    lap_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [4*NUM_DIGITS-1:0] lap_digits_o,
  output logic                    lap_valid_o,
  output logic                    running_o,
  output logic                    wrap_o,
  output logic [1:0]              state_o
);

  // Prescaler needs at least one bit even when a tick fires every cycle.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] c_presc_last = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] c_presc_one  = PW'(1);

  sw_state_t                r_state;
  sw_state_t                w_state_next;
  logic [PW-1:0]            r_presc;
  logic                     w_tick;
  logic [NUM_DIGITS-1:0]    w_en;
  logic [NUM_DIGITS-1:0]    w_at_max;
  logic [4*NUM_DIGITS-1:0]  w_digits;
  logic [4*NUM_DIGITS-1:0]  r_lap_digits;
  logic                     r_lap_valid;
  logic                     r_wrap;
  logic                     w_lap_cap;
  logic                     w_all_max;

  assign w_tick    = (r_state == RUN) && (r_presc == c_presc_last);
  assign w_all_max = &w_at_max;
  assign w_lap_cap = lap_i && ((r_state == RUN) || (r_state == PAUSED));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: clear dominates; stop wins in RUN, start wins elsewhere.
  always_comb begin
    w_state_next = r_state;
    if (clear_i) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start_i) w_state_next = RUN;
        RUN:     if (stop_i)  w_state_next = PAUSED;
        PAUSED:  if (start_i) w_state_next = RUN;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Prescaler advances only in RUN, so a pause keeps its phase.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      r_presc <= '0;
    end else if (r_state == RUN) begin
      r_presc <= w_tick ? '0 : r_presc + c_presc_one;
    end
  end

  // Digit i steps on a tick when every lower digit sits at 9.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign w_en[i] = w_tick;
    end else begin : g_upper
      assign w_en[i] = w_tick && (&w_at_max[i-1:0]);
    end

    bcd_digit u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (clear_i),
      .en_i     (w_en[i]),
      .q_o      (w_digits[4*i +: 4]),
      .at_max_o (w_at_max[i])
    );
  end

  // Lap capture takes the pre-edge count, so a coincident tick is not seen.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      r_lap_digits <= '0;
      r_lap_valid  <= 1'b0;
    end else begin
      r_lap_valid <= w_lap_cap;
      if (w_lap_cap) begin
        r_lap_digits <= w_digits;
      end
    end
  end

  // Wrap pulse follows the tick that rolls all-9s over to zero.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_tick && w_all_max;
    end
  end

  assign digits_o     = w_digits;
  assign lap_digits_o = r_lap_digits;
  assign lap_valid_o  = r_lap_valid;
  assign running_o    = (r_state == RUN);
  assign wrap_o       = r_wrap;
  assign state_o      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bcd_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_stopwatch_ctrl
// Description : Self-checking bench; two instances (TICK_DIV 10 and 1) share
//               stimulus and are tracked by an integer-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_stopwatch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_i, stop_i, clear_i, lap_i;
  logic [15:0] dig_a, lap_a, dig_b, lap_b;
  logic        lv_a, run_a, wrap_a, lv_b, run_b, wrap_b;
  logic [1:0]  st_a, st_b;

  bcd_stopwatch_ctrl #(.NUM_DIGITS(4), .TICK_DIV(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
    .clear_i(clear_i), .lap_i(lap_i), .digits_o(dig_a), .lap_digits_o(lap_a),
    .lap_valid_o(lv_a), .running_o(run_a), .wrap_o(wrap_a), .state_o(st_a)
  );

  bcd_stopwatch_ctrl #(.NUM_DIGITS(4), .TICK_DIV(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
    .clear_i(clear_i), .lap_i(lap_i), .digits_o(dig_b), .lap_digits_o(lap_b),
    .lap_valid_o(lv_b), .running_o(run_b), .wrap_o(wrap_b), .state_o(st_b)
  );

  wire [36:0] obs_a = {st_a, run_a, wrap_a, lv_a, lap_a, dig_a};
  wire [36:0] obs_b = {st_b, run_b, wrap_b, lv_b, lap_b, dig_b};

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0=idle 1=run 2=paused; count is a plain integer.
  int m_mode[2], m_presc[2], m_count[2], m_lap[2];
  bit m_lapv[2], m_wrap[2];
  int div_of[2] = '{10, 1};

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [36:0] exp_vec(input int k);
    return {2'(m_mode[k]), (m_mode[k] == 1), m_wrap[k], m_lapv[k],
            to_bcd(m_lap[k]), to_bcd(m_count[k])};
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic cycle(input bit r, input bit s, input bit p, input bit c, input bit l);
    int nmode[2], npresc[2], ncount[2], nlap[2];
    bit nlapv[2], nwrap[2];
    bit tick;
    rst_n = r; start_i = s; stop_i = p; clear_i = c; lap_i = l;
    for (int k = 0; k < 2; k++) begin
      nmode[k] = m_mode[k]; npresc[k] = m_presc[k];
      ncount[k] = m_count[k]; nlap[k] = m_lap[k];
      nlapv[k] = 1'b0; nwrap[k] = 1'b0;
      if (!r || c) begin
        nmode[k] = 0; npresc[k] = 0; ncount[k] = 0; nlap[k] = 0;
      end else begin
        tick = (m_mode[k] == 1) && (m_presc[k] == div_of[k] - 1);
        if (l && m_mode[k] != 0) begin
          nlap[k] = m_count[k];
          nlapv[k] = 1'b1;
        end
        if (tick) begin
          npresc[k] = 0;
          if (m_count[k] == 9999) begin
            ncount[k] = 0;
            nwrap[k] = 1'b1;
          end else begin
            ncount[k] = m_count[k] + 1;
          end
        end else if (m_mode[k] == 1) begin
          npresc[k] = m_presc[k] + 1;
        end
        if (m_mode[k] == 0 && s) nmode[k] = 1;
        else if (m_mode[k] == 1 && p) nmode[k] = 2;
        else if (m_mode[k] == 2 && s) nmode[k] = 1;
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = nmode[k]; m_presc[k] = npresc[k]; m_count[k] = ncount[k];
      m_lap[k] = nlap[k]; m_lapv[k] = nlapv[k]; m_wrap[k] = nwrap[k];
    end
    #1;
  endtask

  // Run idle-command cycles until the chosen instance shows target, bounded.
  task automatic run_until(input int inst, input logic [15:0] target,
                           input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if ((inst == 0 ? dig_a : dig_b) == target) begin
        ok = 1'b1;
        break;
      end
      cycle(1, 0, 0, 0, 0);
    end
    if (!ok && (inst == 0 ? dig_a : dig_b) == target) ok = 1'b1;
  endtask

  task automatic test_reset;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 1);
    total++;
    if (obs_a !== 37'd0) begin
      bad++; $display("FAIL reset_a: got %h want %h", obs_a, 37'd0);
    end
    total++;
    if (obs_b !== 37'd0) begin
      bad++; $display("FAIL reset_b: got %h want %h", obs_b, 37'd0);
    end
  endtask

  task automatic test_first_tick;
    cycle(1, 1, 0, 0, 0);
    total++;
    if (run_a !== 1'b1) begin
      bad++; $display("FAIL start_running: got %b want 1", run_a);
    end
    for (int n = 0; n < 9; n++) cycle(1, 0, 0, 0, 0);
    total++;
    if (dig_a !== 16'h0000) begin
      bad++; $display("FAIL first_tick_early: got %h want 0000", dig_a);
    end
    cycle(1, 0, 0, 0, 0);
    total++;
    if (dig_a !== 16'h0001) begin
      bad++; $display("FAIL first_tick: got %h want 0001", dig_a);
    end
    total++;
    if (obs_b !== exp_vec(1)) begin
      bad++; $display("FAIL fast_model: got %h want %h", obs_b, exp_vec(1));
    end
  endtask

  task automatic test_pause_resume;
    bit ok;
    bit held;
    run_until(0, 16'h0095, 1200, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL reach_0095: got %h want 0095", dig_a);
    end
    for (int n = 0; n < 3; n++) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0);
    held = 1'b1;
    for (int n = 0; n < 50; n++) begin
      cycle(1, 0, 0, 0, 0);
      if (dig_a !== 16'h0095 || st_a !== 2'b10) held = 1'b0;
    end
    total++;
    if (!held) begin
      bad++; $display("FAIL pause_hold: got %h/%b want 0095/10", dig_a, st_a);
    end
    cycle(1, 1, 0, 0, 0);
    for (int n = 0; n < 45; n++) cycle(1, 0, 0, 0, 0);
    total++;
    if (dig_a !== 16'h0099) begin
      bad++; $display("FAIL phase_before: got %h want 0099", dig_a);
    end
    cycle(1, 0, 0, 0, 0);
    total++;
    if (dig_a !== 16'h0100) begin
      bad++; $display("FAIL phase_resume: got %h want 0100", dig_a);
    end
    total++;
    if (obs_a !== exp_vec(0)) begin
      bad++; $display("FAIL pause_model: got %h want %h", obs_a, exp_vec(0));
    end
  endtask

  task automatic test_wrap;
    bit ok;
    cycle(1, 0, 0, 1, 0);
    cycle(1, 1, 0, 0, 0);
    run_until(1, 16'h9999, 10100, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL reach_9999: got %h want 9999", dig_b);
    end
    cycle(1, 0, 0, 0, 0);
    total++;
    if ({dig_b, wrap_b, run_b} !== {16'h0000, 1'b1, 1'b1}) begin
      bad++; $display("FAIL wrap: got %h/%b/%b want 0000/1/1", dig_b, wrap_b, run_b);
    end
    cycle(1, 0, 0, 0, 0);
    total++;
    if ({dig_b, wrap_b} !== {16'h0001, 1'b0}) begin
      bad++; $display("FAIL wrap_after: got %h/%b want 0001/0", dig_b, wrap_b);
    end
    total++;
    if (obs_a !== exp_vec(0)) begin
      bad++; $display("FAIL wrap_model_a: got %h want %h", obs_a, exp_vec(0));
    end
  endtask

  task automatic test_lap_tick;
    bit ok;
    cycle(1, 0, 0, 1, 0);
    cycle(1, 1, 0, 0, 0);
    run_until(0, 16'h0042, 600, ok);
    for (int n = 0; n < 9; n++) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1);
    total++;
    if ({lap_a, lv_a, dig_a} !== {16'h0042, 1'b1, 16'h0043}) begin
      bad++; $display("FAIL lap_tick: got %h/%b/%h want 0042/1/0043", lap_a, lv_a, dig_a);
    end
    cycle(1, 0, 0, 0, 0);
    total++;
    if (lv_a !== 1'b0 || lap_a !== 16'h0042) begin
      bad++; $display("FAIL lap_pulse: got %b/%h want 0/0042", lv_a, lap_a);
    end
  endtask

  task automatic test_simultaneous;
    cycle(1, 1, 1, 0, 0);
    total++;
    if (st_a !== 2'b10 || run_a !== 1'b0) begin
      bad++; $display("FAIL both_in_run: got %b want 10", st_a);
    end
    cycle(1, 1, 1, 0, 0);
    total++;
    if (st_a !== 2'b01) begin
      bad++; $display("FAIL both_in_paused: got %b want 01", st_a);
    end
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 1, 1);
    total++;
    if ({st_a, dig_a, lap_a, lv_a} !== {2'b00, 16'h0000, 16'h0000, 1'b0}) begin
      bad++; $display("FAIL clear_lap: got %b/%h/%h/%b want 00/0000/0000/0", st_a, dig_a, lap_a, lv_a);
    end
    cycle(1, 0, 1, 0, 1);
    total++;
    if (st_a !== 2'b00 || lv_a !== 1'b0) begin
      bad++; $display("FAIL idle_stop_lap: got %b/%b want 00/0", st_a, lv_a);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    cycle(1, 1, 0, 0, 0);
    run_until(0, 16'h0037, 500, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL reach_0037: got %h want 0037", dig_a);
    end
    cycle(0, 1, 0, 0, 1);
    total++;
    if (obs_a !== 37'd0) begin
      bad++; $display("FAIL reset_mid: got %h want %h", obs_a, 37'd0);
    end
    cycle(1, 0, 0, 0, 0);
    total++;
    if (lv_a !== 1'b0 || st_a !== 2'b00) begin
      bad++; $display("FAIL reset_mid_after: got %b/%b want 0/00", lv_a, st_a);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 4000; n++) begin
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 5) == 0));
      total++;
      if (obs_a !== exp_vec(0)) begin
        bad++; $display("FAIL rand_a@%0d: got %h want %h", n, obs_a, exp_vec(0));
      end
      total++;
      if (obs_b !== exp_vec(1)) begin
        bad++; $display("FAIL rand_b@%0d: got %h want %h", n, obs_b, exp_vec(1));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0; lap_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_presc[k] = 0; m_count[k] = 0; m_lap[k] = 0;
      m_lapv[k] = 1'b0; m_wrap[k] = 1'b0;
    end
    test_reset;
    test_first_tick;
    test_pause_resume;
    test_wrap;
    test_lap_tick;
    test_simultaneous;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
